// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide sequencer for the EX-stage MDU path.
// Radix-2 shift-add multiply and restoring divide on magnitudes; signs are applied in FIX.
module mdu_sequencer #(
    parameter int MUL_FAST = 0,
    parameter int ITER_W   = 6
) (
    input  logic        s_clk_i,
    input  logic        s_resetn_i,
    input  logic        s_start_i,
    input  logic        s_stall_i,
    input  logic        s_flush_i,
    input  logic [2:0]  s_funct_i,
    input  logic [31:0] s_operand1_i,
    input  logic [31:0] s_operand2_i,
    output logic        s_busy_o,
    output logic        s_finished_o,
    output logic [31:0] s_result_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } state_e;

    localparam logic [2:0] F_MUL    = 3'd0;
    localparam logic [2:0] F_MULH   = 3'd1;
    localparam logic [2:0] F_MULHSU = 3'd2;
    localparam logic [2:0] F_DIV    = 3'd4;
    localparam logic [2:0] F_REM    = 3'd6;

    state_e            state_q, state_d;
    logic [2:0]        funct_q, funct_d;
    logic [31:0]       op1_q, op1_d;
    logic [31:0]       op2_q, op2_d;
    logic              sign1_q, sign1_d;
    logic              sign2_q, sign2_d;
    logic [63:0]       acc_q, acc_d;
    logic [ITER_W-1:0] cnt_q, cnt_d;
    logic [31:0]       result_q, result_d;

    logic        in_div, in_sign1, in_sign2, in_div0, in_ovf, in_special;
    logic [63:0] fast_a, fast_b, fast_prod;
    logic [31:0] special_res;

    // Decode of the instruction waiting in EX; only consumed while IDLE.
    always_comb begin
        in_div    = s_funct_i[2];
        in_sign1  = s_operand1_i[31] &
                    (s_funct_i inside {F_MULH, F_MULHSU, F_DIV, F_REM});
        in_sign2  = s_operand2_i[31] & (s_funct_i inside {F_MULH, F_DIV, F_REM});
        in_div0   = in_div & (s_operand2_i == 32'd0);
        in_ovf    = ((s_funct_i == F_DIV) || (s_funct_i == F_REM)) &&
                    (s_operand1_i == 32'h8000_0000) && (s_operand2_i == 32'hFFFF_FFFF);
        fast_a    = {{32{in_sign1}}, s_operand1_i};
        fast_b    = {{32{in_sign2}}, s_operand2_i};
        fast_prod = (MUL_FAST != 0) ? fast_a * fast_b : 64'd0;
        in_special = in_div0 | in_ovf | (~in_div & (MUL_FAST != 0));
        if (in_div0) begin
            special_res = s_funct_i[1] ? s_operand1_i : 32'hFFFF_FFFF;
        end else if (in_ovf) begin
            special_res = s_funct_i[1] ? 32'd0 : 32'h8000_0000;
        end else begin
            special_res = (s_funct_i == F_MUL) ? fast_prod[31:0] : fast_prod[63:32];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (s_flush_i) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (s_start_i) state_d = in_special ? ST_DONE : ST_PREP;
                ST_PREP: state_d = ST_CALC;
                ST_CALC: if (cnt_q == ITER_W'(1)) state_d = ST_FIX;
                ST_FIX:  state_d = ST_DONE;
                ST_DONE: if (!s_stall_i) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        s_busy_o     = (state_q != ST_IDLE);
        s_finished_o = (state_q == ST_DONE);
    end

    assign s_result_o = result_q;

    logic [32:0] mul_sum;
    logic [32:0] rem_sh;
    logic [32:0] trial;
    logic [63:0] prod_signed;
    logic [31:0] quo_signed, rem_signed;

    always_comb begin
        mul_sum     = {1'b0, acc_q[63:32]} + (op2_q[0] ? {1'b0, op1_q} : 33'd0);
        rem_sh      = {acc_q[63:32], op1_q[31]};
        trial       = rem_sh - {1'b0, op2_q};
        prod_signed = (sign1_q ^ sign2_q) ? (64'd0 - acc_q) : acc_q;
        quo_signed  = (sign1_q ^ sign2_q) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        rem_signed  = sign1_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    end

    // NOTE: every next-state signal starts from its held value so no path
    // through this block leaves one unassigned (no latches).
    always_comb begin
        funct_d  = funct_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        sign1_d  = sign1_q;
        sign2_d  = sign2_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (s_flush_i) begin
            cnt_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (s_start_i) begin
                        funct_d = s_funct_i;
                        op1_d   = s_operand1_i;
                        op2_d   = s_operand2_i;
                        sign1_d = in_sign1;
                        sign2_d = in_sign2;
                        if (in_special) result_d = special_res;
                    end
                end
                ST_PREP: begin
                    if (sign1_q) op1_d = 32'd0 - op1_q;
                    if (sign2_q) op2_d = 32'd0 - op2_q;
                    acc_d = 64'd0;
                    cnt_d = ITER_W'(32);
                end
                ST_CALC: begin
                    cnt_d = cnt_q - ITER_W'(1);
                    if (funct_q[2]) begin
                        // Remainder in the upper word, quotient bits enter at the bottom.
                        op1_d = {op1_q[30:0], 1'b0};
                        if (!trial[32]) begin
                            acc_d = {trial[31:0], acc_q[30:0], 1'b1};
                        end else begin
                            acc_d = {rem_sh[31:0], acc_q[30:0], 1'b0};
                        end
                    end else begin
                        op2_d = {1'b0, op2_q[31:1]};
                        acc_d = {mul_sum, acc_q[31:1]};
                    end
                end
                ST_FIX: begin
                    if (funct_q[2]) begin
                        result_d = funct_q[1] ? rem_signed : quo_signed;
                    end else begin
                        result_d = (funct_q == F_MUL) ? prod_signed[31:0] : prod_signed[63:32];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
        if (!s_resetn_i) begin
            funct_q  <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            sign1_q  <= 1'b0;
            sign2_q  <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            funct_q  <= funct_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            sign1_q  <= sign1_d;
            sign2_q  <= sign2_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: one iterative and one fast-multiply instance.
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_s, start_f, stall, flush;
    logic [2:0]  funct;
    logic [31:0] op1, op2;
    logic        busy_s, fin_s, busy_f, fin_f;
    logic [31:0] res_s, res_f;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mdu_sequencer #(.MUL_FAST(0), .ITER_W(6)) u_slow (
        .s_clk_i(clk), .s_resetn_i(rst_n), .s_start_i(start_s), .s_stall_i(stall),
        .s_flush_i(flush), .s_funct_i(funct), .s_operand1_i(op1), .s_operand2_i(op2),
        .s_busy_o(busy_s), .s_finished_o(fin_s), .s_result_o(res_s)
    );

    mdu_sequencer #(.MUL_FAST(1), .ITER_W(6)) u_fast (
        .s_clk_i(clk), .s_resetn_i(rst_n), .s_start_i(start_f), .s_stall_i(stall),
        .s_flush_i(flush), .s_funct_i(funct), .s_operand1_i(op1), .s_operand2_i(op2),
        .s_busy_o(busy_f), .s_finished_o(fin_f), .s_result_o(res_f)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic launch(input bit fast, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        funct = f;
        op1   = a;
        op2   = b;
        if (fast) start_f = 1'b1;
        else      start_s = 1'b1;
    endtask

    // Start is assumed to be sampled by the next posedge (cycle 0).
    task automatic wait_finish(input bit fast, input int exp_lat, input logic [31:0] exp_res,
                               input string tag, input bit scramble);
        int          lat = 0;
        logic [31:0] res = '0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            if (scramble && c == 3) begin
                op1 = 32'hDEAD_BEEF;
                op2 = 32'h0000_0003;
            end
            if (fast ? fin_f : fin_s) begin
                lat = c;
                res = fast ? res_f : res_s;
                break;
            end
        end
        start_s = 1'b0;
        start_f = 1'b0;
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, res, exp_res);
    endtask

    task automatic do_op(input bit fast, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input int exp_lat, input string tag, input bit scramble);
        launch(fast, f, a, b);
        wait_finish(fast, exp_lat, exp_res, tag, scramble);
        @(posedge clk);
        #1;
        check({tag, "_idle"}, 32'(fast ? busy_f : busy_s), 32'd0);
    endtask

    initial begin
        logic saw_fin;
        rst_n   = 1'b0;
        start_s = 1'b0;
        start_f = 1'b0;
        stall   = 1'b0;
        flush   = 1'b0;
        funct   = 3'd0;
        op1     = '0;
        op2     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy_s", 32'(busy_s), 32'd0);
        check("rst_fin_s",  32'(fin_s),  32'd0);
        check("rst_res_s",  res_s,       32'd0);
        check("rst_busy_f", 32'(busy_f), 32'd0);
        check("rst_fin_f",  32'(fin_f),  32'd0);
        check("rst_res_f",  res_f,       32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(0, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35, "div_m7_2", 0);
        do_op(0, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35, "rem_m7_2", 0);
        do_op(0, 3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, 1, "divu_by0", 0);
        do_op(0, 3'd7, 32'd100, 32'd0, 32'd100,       1, "remu_by0", 0);
        do_op(0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf", 0);
        do_op(0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, "rem_ovf", 0);

        do_op(0, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 35, "s_mulh",   0);
        do_op(0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 35, "s_mulhsu", 0);
        do_op(0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 35, "s_mulhu",  0);
        do_op(0, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 35, "s_mul",    0);
        do_op(1, 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1, "f_mulh",   0);
        do_op(1, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, "f_mulhsu", 0);
        do_op(1, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, "f_mulhu",  0);
        do_op(1, 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1, "f_mul",    0);

        do_op(0, 3'd4, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 35, "div_100_m7", 1);
        do_op(0, 3'd6, 32'hFFFF_FF9C, 32'd7,   32'hFFFF_FFFE, 35, "rem_m100_7", 1);
        do_op(0, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 35, "s_mulh_min", 0);
        do_op(1, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1,  "f_mulh_min", 0);
        do_op(0, 3'd3, 32'h8000_0000, 32'd2, 32'h0000_0001, 35, "mulhu_2p32", 0);
        do_op(0, 3'd5, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 35, "divu_max_1", 0);
        do_op(1, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35, "f_div_m7_2", 0);

        // Flush in cycle 10 of a DIVU with start held high throughout.
        launch(0, 3'd5, 32'd1000, 32'd7);
        saw_fin = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            saw_fin = saw_fin | fin_s;
        end
        check("flush_busy_c10", 32'(busy_s), 32'd1);
        @(negedge clk);
        flush = 1'b1;
        op1   = 32'd50;
        op2   = 32'd5;
        @(posedge clk);
        #1;
        saw_fin = saw_fin | fin_s;
        check("flush_idle_c11", 32'(busy_s), 32'd0);
        check("flush_no_fin",   32'(saw_fin), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        wait_finish(0, 35, 32'd10, "after_flush", 0);
        @(posedge clk);
        #1;
        check("after_flush_idle", 32'(busy_s), 32'd0);

        // Hold DONE with stall for 4 cycles.
        stall = 1'b1;
        launch(0, 3'd5, 32'd77, 32'd7);
        wait_finish(0, 35, 32'd11, "stall_op", 0);
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            #1;
            check("stall_fin", 32'(fin_s), 32'd1);
            check("stall_res", res_s, 32'd11);
        end
        stall = 1'b0;
        @(posedge clk);
        #1;
        check("stall_rel_busy", 32'(busy_s), 32'd0);
        check("stall_rel_fin",  32'(fin_s),  32'd0);

        // Asynchronous reset in the middle of an operation.
        launch(0, 3'd5, 32'd900, 32'd9);
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy_s), 32'd0);
        check("midrst_fin",  32'(fin_s),  32'd0);
        check("midrst_res",  res_s,       32'd0);
        start_s = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_op(0, 3'd5, 32'd900, 32'd9, 32'd100, 35, "post_rst", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Iterative multiply/divide controller for the EX stage MDU path (RISC-V M extension).
- Latches operands when an MDU instruction enters EX and sequences a radix-2 shift-add/restoring-divide datapath.
- Raises a finished flag that the EX stage uses to stop bubbling the pipeline, and holds the result until the instruction leaves EX.
- Exposes per-replica scalar ports; the EX stage instantiates one copy per protection replica.

Parameters:
- MUL_FAST, 0, 1 = multiplications complete via a single-cycle combinational 32x32 multiplier (IDLE->DONE); 0 = iterative.
- ITER_W, 6, width of the iteration counter (must hold 33).

Ports:
- s_clk_i  input  1  clock
- s_resetn_i  input  1  asynchronous active-low reset
- s_start_i  input  1  MDU instruction present in EX; level, held until finished and consumed
- s_stall_i  input  1  EX stage stalled by MA stage; result must be held
- s_flush_i  input  1  abort current operation
- s_funct_i  input  3  RISC-V funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- s_operand1_i  input  32  rs1 value (dividend / multiplicand)
- s_operand2_i  input  32  rs2 value (divisor / multiplier)
- s_busy_o  output  1  state != IDLE
- s_finished_o  output  1  result valid this cycle (state == DONE)
- s_result_o  output  32  result; registered, stable while s_finished_o=1

Behaviour:
- Clock and reset: one clock (s_clk_i). Reset is asynchronous, active-low (s_resetn_i).
- Reset values: state IDLE, counter 0, all datapath registers 0, s_busy_o=0, s_finished_o=0, s_result_o=0.
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE:
  - If s_start_i & ~s_flush_i: latch funct, operands and sign flags.
  - Special cases go directly to DONE with the result registered:
    - div/rem with operand2==0: quotient 0xFFFFFFFF, remainder = operand1.
    - signed overflow (0x80000000 / 0xFFFFFFFF): DIV=0x80000000, REM=0.
    - any MUL* when MUL_FAST=1.
  - Otherwise go to PREP.
- PREP:
  - Take absolute values for signed ops (DIV, REM, MULH both operands; MULHSU operand1 only).
  - Clear the 64-bit accumulator; counter=32; go to CALC.
- CALC:
  - One bit per cycle.
  - Multiply: conditional add of the multiplicand into the upper half, then right shift.
  - Divide: restoring; left-shift the remainder, trial-subtract the divisor, set the quotient bit if non-negative.
  - Counter decrements; when counter==1 on the clock edge, go to FIX.
- FIX:
  - Apply result sign and select the result: low/high product word, quotient or remainder.
  - Quotient sign = sign1^sign2; remainder sign = dividend sign.
  - Go to DONE.
- DONE:
  - s_finished_o=1.
  - If ~s_stall_i, go to IDLE next cycle (result consumed).
  - If s_stall_i, remain in DONE with s_result_o unchanged.
  - s_start_i is ignored in DONE.
- Latency (start sampled in cycle 0):
  - Iterative op: s_finished_o high in cycle 35.
  - Special case or fast MUL: high in cycle 1.
- Flush: from any state, go to IDLE on the next edge. s_finished_o is low from the next cycle and the counter is cleared. Flush has priority over start in the same cycle.
- Start while busy: ignored; operands are never re-latched mid-operation.
- Stall during PREP/CALC/FIX: computation continues; stall only affects leaving DONE.
- Back-to-back: an instruction can start in the cycle after DONE->IDLE. There is no combinational start-to-finish path.
- Reset mid-operation: immediate return to reset values.
- Arithmetic: all internal operations unsigned on 33/64-bit registers; signs are applied only in FIX; results wrap modulo 2^32.

Test Plan:
- DIV 0xFFFFFFF9 (-7) / 2, no stall -> s_finished_o rises exactly cycle 35, s_result_o=0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
- DIVU 100 / 0 -> finished in cycle 1, result 0xFFFFFFFF; REMU 100 / 0 -> 100.
- DIV 0x80000000 / 0xFFFFFFFF -> cycle 1, result 0x80000000; REM -> 0.
- MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000; MULHSU same -> 0xFFFFFFFF; MULHU same -> 0xFFFFFFFE; MUL -> 0x00000001. Run with MUL_FAST=0 (cycle 35) and MUL_FAST=1 (cycle 1).
- Flush asserted at cycle 10 of a DIVU, start held high throughout -> IDLE at cycle 11, s_finished_o never asserted for the aborted op. The next start (operands 50/5) -> result 10 at start+35.
- DONE with s_stall_i high for 4 cycles -> s_finished_o and s_result_o stable for 5 cycles. Release stall -> IDLE next cycle, s_busy_o=0.
